// File: rtl/extensor_signo_pipe.sv
// Two-stage pipelined sign/zero extender with optional shift-left-saturate
// alignment, valid/ready handshaking on both sides and a transfer counter.
module extensor_signo_pipe #(
   parameter int N_IN  = 24,
   parameter int N_OUT = 48,
   parameter int SH_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_data,
   input  logic [1:0]       modo,
   input  logic [SH_W-1:0]  shamt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_OUT-1:0] out_data,
   output logic             out_sat,
   output logic [31:0]      cuenta
);

   // Exact shift width: enough sign bits survive any shift amount
   localparam int FW = N_OUT + (2 ** SH_W);

   typedef enum logic [1:0] {
      MODO_SIGNO   = 2'b00,
      MODO_CERO    = 2'b01,
      MODO_DESPL   = 2'b10,
      MODO_SIGNO_B = 2'b11
   } modo_t;

   if (N_OUT < N_IN) begin : g_chk_ancho
      $error("extensor_signo_pipe: N_OUT must be >= N_IN");
   end
   if ((2 ** SH_W) <= N_OUT) begin : g_chk_shamt
      $error("extensor_signo_pipe: 2**SH_W must exceed N_OUT");
   end

   logic              s1_valid;
   logic [N_OUT-1:0]  s1_ext;
   modo_t             s1_modo;
   logic [SH_W-1:0]   s1_shamt;

   logic              s2_load;
   logic [N_OUT-1:0]  ext_in;
   logic [N_OUT-1:0]  s2_data;
   logic              s2_sat;
   logic [FW-1:0]     wide;
   logic [FW-1:0]     full;
   logic [FW-N_OUT:0] upper;

   // Output stage refills when empty or draining; S1 follows it
   assign s2_load  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;

   // Widen the incoming sample: zero-extend only for modo 01
   always_comb begin
      ext_in = N_OUT'(signed'(in_data));
      if (modo_t'(modo) == MODO_CERO) begin
         ext_in = N_OUT'(in_data);
      end
   end

   // Shift the S1 value exactly; it fits iff the top bits down to the new sign bit agree
   always_comb begin
      wide    = FW'(signed'(s1_ext));
      full    = wide << s1_shamt;
      upper   = full[FW-1:N_OUT-1];
      s2_data = s1_ext;
      s2_sat  = 1'b0;
      if (s1_modo == MODO_DESPL) begin
         if ((upper == '0) || (upper == '1)) begin
            s2_data = full[N_OUT-1:0];
         end else begin
            s2_sat = 1'b1;
            if (full[FW-1]) begin
               s2_data = {1'b1, {(N_OUT-1){1'b0}}};
            end else begin
               s2_data = {1'b0, {(N_OUT-1){1'b1}}};
            end
         end
      end
   end

   // Stage 1: capture the extended sample with its mode and shift amount
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_ext   <= '0;
         s1_modo  <= MODO_SIGNO;
         s1_shamt <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_ext   <= ext_in;
            s1_modo  <= modo_t'(modo);
            s1_shamt <= shamt;
         end
      end
   end

   // Stage 2: register the aligned result; holds while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= s2_data;
            out_sat  <= s2_sat;
         end
      end
   end

   // Count completed output transfers, wrapping naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cuenta <= '0;
      end else if (out_valid && out_ready) begin
         cuenta <= cuenta + 32'd1;
      end
   end

endmodule

// File: tb/tb_extensor_signo_pipe.sv
// Scoreboard bench for extensor_signo_pipe: directed mode/saturation cases,
// backpressure, random streaming and asynchronous reset with data in flight.
module tb_extensor_signo_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_data = '0;
   logic [1:0]  modo = '0;
   logic [5:0]  shamt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [47:0] out_data;
   logic        out_sat;
   logic [31:0] cuenta;

   int          errors = 0;
   int          checks = 0;
   logic [48:0] sb[$];
   logic [48:0] exp_v;
   bit          rand_ready = 1'b0;

   localparam logic signed [127:0] MAXP = 128'sh7FFF_FFFF_FFFF;
   localparam logic signed [127:0] MINN = -128'sh8000_0000_0000;

   extensor_signo_pipe #(.N_IN(24), .N_OUT(48), .SH_W(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .modo(modo), .shamt(shamt), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .cuenta(cuenta)
   );

   always #5 clk = ~clk;

   // Reference: arithmetic range compare on a 128-bit signed value, result {sat, data}
   function automatic logic [48:0] model(input logic [23:0] d, input logic [1:0] m, input logic [5:0] s);
      logic signed [127:0] v;
      logic signed [127:0] f;
      if (m == 2'b01) return {1'b0, 24'h0, d};
      v = {{104{d[23]}}, d};
      if (m != 2'b10) return {1'b0, v[47:0]};
      f = v <<< s;
      if (f > MAXP) return {1'b1, 48'h7FFF_FFFF_FFFF};
      if (f < MINN) return {1'b1, 48'h8000_0000_0000};
      return {1'b0, f[47:0]};
   endfunction

   // Output side of the scoreboard: every output transfer pops one expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got sat=%b data=%h with nothing expected", out_sat, out_data);
         end else begin
            exp_v = sb.pop_front();
            if ({out_sat, out_data} !== exp_v) begin
               errors++;
               $display("FAIL output_value: got sat=%b data=%h, expected sat=%b data=%h",
                        out_sat, out_data, exp_v[48], exp_v[47:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Present one sample until accepted; push its expectation at acceptance
   task automatic send(input logic [23:0] d, input logic [1:0] m, input logic [5:0] s,
                       input logic [48:0] e);
      bit done = 1'b0;
      int n = 0;
      in_data = d; modo = m; shamt = s; in_valid = 1'b1;
      while (!done && n < 200) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            done = 1'b1;
         end
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
      end
   endtask

   task automatic drain();
      int n = 0;
      rand_ready = 1'b0;
      out_ready = 1'b1;
      while (sb.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d outstanding, required 0", sb.size());
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if ({out_valid, out_sat, out_data, cuenta} !== 82'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b s=%b d=%h c=%h, required all zero",
                  out_valid, out_sat, out_data, cuenta);
      end
      do_reset();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
   endtask

   task automatic test_latency();
      out_ready = 1'b1;
      send(24'h800000, 2'b00, 6'd0, {1'b0, 48'hFFFF_FF80_0000});
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 48'hFFFF_FF80_0000) begin
         errors++;
         $display("FAIL latency_two: v=%b d=%h, required v=1 d=ffffff800000", out_valid, out_data);
      end
      tick();
      checks++;
      if (cuenta !== 32'd1) begin
         errors++;
         $display("FAIL cuenta_first: got %0d, required 1", cuenta);
      end
   endtask

   task automatic test_modes();
      out_ready = 1'b1;
      send(24'h800000, 2'b01, 6'd9,  {1'b0, 48'h0000_0080_0000});
      send(24'h7FFFFF, 2'b11, 6'd30, {1'b0, 48'h0000_007F_FFFF});
      send(24'hFFFFFF, 2'b00, 6'd0,  {1'b0, 48'hFFFF_FFFF_FFFF});
      drain();
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      send(24'h000001, 2'b10, 6'd4,  {1'b0, 48'h0000_0000_0010});
      send(24'h7FFFFF, 2'b10, 6'd24, {1'b0, 48'h7FFF_FF00_0000});
      send(24'h7FFFFF, 2'b10, 6'd25, {1'b1, 48'h7FFF_FFFF_FFFF});
      send(24'h800000, 2'b10, 6'd24, {1'b0, 48'h8000_0000_0000});
      send(24'h800000, 2'b10, 6'd25, {1'b1, 48'h8000_0000_0000});
      send(24'h000000, 2'b10, 6'd63, {1'b0, 48'h0000_0000_0000});
      send(24'h000001, 2'b10, 6'd48, {1'b1, 48'h7FFF_FFFF_FFFF});
      send(24'hFFFFFF, 2'b10, 6'd47, {1'b0, 48'h8000_0000_0000});
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      send(24'h123456, 2'b00, 6'd0, {1'b0, 48'h0000_0012_3456});
      send(24'hABCDEF, 2'b01, 6'd0, {1'b0, 48'h0000_00AB_CDEF});
      in_data = 24'hFEDCBA; modo = 2'b10; shamt = 6'd8; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 48'h0000_0012_3456 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: rdy=%b v=%b d=%h s=%b, required rdy=0 v=1 d=000000123456 s=0",
                     in_ready, out_valid, out_data, out_sat);
         end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready: in_ready=%b, required 1", in_ready);
      end else begin
         sb.push_back({1'b0, 48'hFFFF_FEDC_BA00});
      end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: out_valid=%b at drain cycle %0d, required 1", out_valid, i + 1);
         end
         tick();
      end
      checks++;
      if (cuenta !== 32'd3 || sb.size() != 0) begin
         errors++;
         $display("FAIL bp_count: cuenta=%0d pending=%0d, required 3 and 0", cuenta, sb.size());
      end
   endtask

   task automatic test_stream();
      logic [23:0] d;
      logic [1:0]  m;
      logic [5:0]  s;
      do_reset();
      rand_ready = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         while ($urandom_range(0, 1) == 0) tick();
         d = 24'($urandom);
         if ($urandom_range(0, 3) == 0) d = 24'($signed(d) >>> $urandom_range(0, 23));
         m = 2'($urandom_range(0, 3));
         s = 6'($urandom_range(0, 63));
         send(d, m, s, model(d, m, s));
      end
      drain();
      checks++;
      if (cuenta !== 32'd5000) begin
         errors++;
         $display("FAIL stream_count: cuenta=%0d, required 5000", cuenta);
      end
   endtask

   task automatic test_reset_inflight();
      out_ready = 1'b0;
      send(24'h000111, 2'b00, 6'd0, {1'b0, 48'h0000_0000_0111});
      send(24'h000222, 2'b00, 6'd0, {1'b0, 48'h0000_0000_0222});
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || cuenta !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: v=%b cuenta=%0d, required 0 and 0", out_valid, cuenta);
      end
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(24'hC00001, 2'b10, 6'd2, {1'b0, 48'hFFFF_FF00_0004});
      repeat (6) tick();
      checks++;
      if (cuenta !== 32'd1 || sb.size() != 0) begin
         errors++;
         $display("FAIL post_reset: cuenta=%0d pending=%0d, required 1 and 0", cuenta, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_modes();
      test_saturation();
      test_backpressure();
      test_stream();
      test_reset_inflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/extensor_signo_pipe.md
Name: extensor_signo_pipe

Overview:
Parametrised, pipelined successor to the combinational 24->48 bit sign extender used on the filter accumulator path. Widens an N_IN-bit fixed-point sample to N_OUT bits with selectable sign/zero extension. Optionally left-shifts for fractional-point alignment with signed saturation. Sits between the adder output and the wide accumulator, with valid/ready flow control and a transfer counter for bench/debug.

Parameters:
N_IN, 24, input sample width (bits).
N_OUT, 48, output width; N_OUT >= N_IN is required, elaboration error otherwise.
SH_W, 6, width of shift-amount port; must satisfy 2^SH_W > N_OUT.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  input sample valid
in_ready  output  1  block can accept a sample this cycle
in_data  input  N_IN  input sample, two's complement unless modo=01
modo  input  2  00 sign-extend; 01 zero-extend; 10 sign-extend then shift-left-saturate; 11 treated as 00
shamt  input  SH_W  left-shift amount, used only in modo=10
out_valid  output  1  output sample valid
out_ready  input  1  downstream accepts output
out_data  output  N_OUT  extended/aligned result
out_sat  output  1  saturation occurred on this output sample
cuenta  output  32  number of completed output transfers

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sat=0, cuenta=0, both pipeline stages invalid. in_ready=1 after rst deasserts.
- Reset mid-operation: all in-flight samples are discarded; no partial output.
- Input transfer: in_valid & in_ready at a rising edge. modo and shamt are sampled with in_data.
- Output transfer: out_valid & out_ready at a rising edge.
- Two-stage pipeline:
  - S1 registers the extended value (N_OUT bits), modo and shamt.
  - S2 performs the shift/saturation and drives the output registers.
  - Latency is 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 sample/cycle.
- Flow control:
  - S2 loads when it is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !S1_valid | S2_loads. This is combinational from out_ready; there is no path from in_valid to in_ready.
- Stall: while out_valid=1 and out_ready=0, out_data and out_sat hold stable. With out_ready held low, at most 2 samples are accepted.
- modo 00/11: out_data = {(N_OUT-N_IN){in_data[N_IN-1]}, in_data}; out_sat=0.
- modo 01: out_data = zero-padded in_data; out_sat=0; shamt ignored.
- modo 10: full = sign-extended value × 2^shamt, computed exactly (internal width N_OUT+2^SH_W or equivalent overflow check).
  - If full lies in the signed N_OUT range: out_data = full[N_OUT-1:0], out_sat=0.
  - If full > 2^(N_OUT-1)-1: out_data = 0 followed by all ones, out_sat=1.
  - If full < -2^(N_OUT-1): out_data = 1 followed by all zeros, out_sat=1.
  - Zero input never saturates, for any shamt.
  - shamt >= N_OUT with nonzero input always saturates.
- cuenta increments by 1 on every output transfer and wraps from 0xFFFFFFFF to 0.
- A simultaneous input and output transfer with both stages full is legal: the pipeline advances one slot and no sample is lost or duplicated.

Test Plan:
- Reset, then modo=00, in_data=24'h800000, out_ready=1 -> 2 cycles later out_valid=1, out_data=48'hFFFFFF800000, out_sat=0, cuenta=1.
- modo=01, in_data=24'h800000 -> out_data=48'h000000800000, out_sat=0. modo=11, in_data=24'h7FFFFF -> out_data=48'h0000007FFFFF.
- modo=10 cases (saturation boundary):
  - in_data=24'h000001, shamt=4 -> 48'h000000000010, out_sat=0.
  - in_data=24'h7FFFFF, shamt=24 -> 48'h7FFFFF000000, out_sat=0.
  - in_data=24'h7FFFFF, shamt=25 -> 48'h7FFFFFFFFFFF, out_sat=1.
  - in_data=24'h800000, shamt=24 -> 48'h800000000000, out_sat=0.
  - in_data=24'h800000, shamt=25 -> 48'h800000000000, out_sat=1.
  - in_data=0, shamt=63 -> 48'h0, out_sat=0.
- Backpressure: out_ready=0, in_valid=1 with 3 samples A,B,C -> only A,B accepted, in_ready=0. out_data=A held stable for 5 cycles. Raising out_ready -> outputs A,B,C in order on consecutive cycles, cuenta=3.
- Streaming: 5000 random samples of random modo/shamt, in_valid and out_ready each randomly toggled at 50% -> output sequence matches a reference model bit-exactly, no drops or duplicates, cuenta=5000.
- Assert rst with 2 samples in flight -> out_valid=0 and cuenta=0 immediately (asynchronously). After release, the next sample appears alone with the correct value.
